crc_frame_arbiter: RTL
======================

Name: crc_frame_arbiter

Overview:
Shares one byte-serial CRC-32 engine (clk/rst/start/DataIn[7:0] -> CRCOut[31:0]/done) between two byte-stream requesters. It grants the engine per frame, round-robin. It clears the engine at each frame start and feeds bytes one at a time with the engine's start/done handshake. It returns the final Ethernet FCS, tagged with the requester id. It sits between the MAC TX framers and the CRC engine instance.

Parameters:
DATA_WIDTH, 8, byte width of requester and engine data.
CRC_WIDTH, 32, engine result width.
FINAL_XOR, 32'hFFFFFFFF, XOR applied to the engine CRCOut to form res_crc.
CLR_CYCLES, 2, cycles eng_rst is held high at frame start.
TIMEOUT_CYCLES, 64, maximum cycles in FEED without an eng_done rising edge.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
req0_valid  in  1  requester 0 byte valid.
req0_data  in  DATA_WIDTH  requester 0 byte.
req0_last  in  1  requester 0 final byte of frame.
req0_ready  out  1  requester 0 byte accepted when valid&ready.
req1_valid, req1_data, req1_last, req1_ready: same as req0 for requester 1.
res_valid  out  1  one-cycle result strobe.
res_id  out  1  requester that owns res_crc.
res_crc  out  CRC_WIDTH  eng_crc ^ FINAL_XOR.
res_err  out  1  qualifies res_valid: engine timeout, res_crc invalid.
eng_rst  out  1  drives engine rst.
eng_start  out  1  drives engine start.
eng_data  out  DATA_WIDTH  drives engine DataIn.
eng_done  in  1  engine done.
eng_crc  in  CRC_WIDTH  engine CRCOut.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, eng_rst=1, all other outputs 0.
  - last_grant=1, so req0 wins the first tie.
  - done_q=0, timer=0.
- States: IDLE, CLR, WAIT_BYTE, FEED, RESULT.
- IDLE:
  - eng_rst=0.
  - If either reqN_valid=1: grant=the requester not equal to last_grant if it is valid, else the valid one.
  - Latch grant, go to CLR.
  - Arbitration happens only here; the grant holds for the whole frame.
- CLR:
  - eng_rst=1 for exactly CLR_CYCLES cycles.
  - Then go to WAIT_BYTE with eng_rst=0.
- WAIT_BYTE:
  - ready of the granted requester=1; the other requester's ready=0 in every state.
  - On valid&ready: latch data into eng_data, latch last, go to FEED.
- FEED:
  - eng_start=1 and eng_data held stable from the first FEED cycle.
  - done_q registers eng_done every cycle. A rising edge is eng_done=1 & done_q=0.
  - On a rising edge: eng_start=0 next cycle.
    - If latched last=1, go to RESULT.
    - Otherwise go to WAIT_BYTE.
  - Next byte earliest: ready reasserts the cycle after the edge is seen, so there is one idle start cycle per byte minimum.
- Timeout:
  - timer counts FEED cycles and clears on FEED entry.
  - If timer reaches TIMEOUT_CYCLES with no edge: go to RESULT with err=1.
  - Remaining bytes of that frame stay unaccepted until the requester's next grant. The requester is responsible for flushing.
- RESULT:
  - res_valid=1 for one cycle.
  - res_id=grant, res_crc=eng_crc^FINAL_XOR (sampled this cycle), res_err=err.
  - last_grant<=grant, err<=0, go to IDLE.
- res_id, res_crc and res_err hold their values until the next RESULT. Consumers qualify them with res_valid only.
- Simultaneous events:
  - Both requesters valid in IDLE: alternate.
  - A new request arriving during the RESULT cycle waits for IDLE (1 cycle).
- last=1 on the first byte gives a 1-byte frame. An empty frame is not possible.
- reqN_valid deasserting mid-frame just stalls in WAIT_BYTE (no timeout there).
- Reset mid-frame:
  - Discards everything, no res_valid.
  - eng_rst=1 keeps the engine cleared.

Test Plan:
- Single frame, req0, byte 0x00 with last=1 -> one res_valid, res_id=0, res_crc=32'hD202EF8D, res_err=0; eng_rst high exactly 2 cycles before first eng_start.
- req1 frame "123456789" (0x31..0x39, last on 0x39) -> res_crc=32'hCBF43926, res_id=1; req0_ready stays 0 throughout; eng_data stable while eng_start=1.
- req0 and req1 both valid from reset, 3 frames each -> res_id sequence 0,1,0,1,0,1; no interleaved bytes inside a frame.
- Engine model with done never rising on byte 2 -> exactly TIMEOUT_CYCLES=64 FEED cycles then res_valid with res_err=1; next frame of the other requester returns correct CRC.
- Async rst pulse during FEED of byte 4 of a 9-byte frame -> outputs 0 and eng_rst=1 within the same cycle, no res_valid; re-send "123456789" -> 32'hCBF43926.
- req0 valid toggling 0/1 every 3 cycles mid-frame -> result unchanged (32'hCBF43926), no timeout.

Source files
------------

// File: rtl/crc_frame_arbiter_if.sv
// -----------------------------------------------------------------------------
// crc_frame_arbiter_if
// Bundles the requester byte streams, the tagged result strobe and the
// byte-serial CRC engine handshake used by crc_frame_arbiter.
//   slave  : the arbiter's view (consumes requests, drives engine + result)
//   master : the environment's view (requesters, engine, result consumer)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface crc_frame_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CRC_WIDTH  = 32
);
  logic                  req0_valid;
  logic [DATA_WIDTH-1:0] req0_data;
  logic                  req0_last;
  logic                  req0_ready;
  logic                  req1_valid;
  logic [DATA_WIDTH-1:0] req1_data;
  logic                  req1_last;
  logic                  req1_ready;
  logic                  res_valid;
  logic                  res_id;
  logic [CRC_WIDTH-1:0]  res_crc;
  logic                  res_err;
  logic                  eng_rst;
  logic                  eng_start;
  logic [DATA_WIDTH-1:0] eng_data;
  logic                  eng_done;
  logic [CRC_WIDTH-1:0]  eng_crc;

  modport slave (
    input  req0_valid, req0_data, req0_last,
    input  req1_valid, req1_data, req1_last,
    input  eng_done, eng_crc,
    output req0_ready, req1_ready,
    output res_valid, res_id, res_crc, res_err,
    output eng_rst, eng_start, eng_data
  );

  modport master (
    output req0_valid, req0_data, req0_last,
    output req1_valid, req1_data, req1_last,
    output eng_done, eng_crc,
    input  req0_ready, req1_ready,
    input  res_valid, res_id, res_crc, res_err,
    input  eng_rst, eng_start, eng_data
  );
endinterface

// File: rtl/crc_frame_arbiter.sv
// -----------------------------------------------------------------------------
// crc_frame_arbiter
// Shares one byte-serial CRC-32 engine between two byte-stream requesters.
// Grants whole frames round-robin, clears the engine at frame start, feeds
// bytes through the engine start/done handshake and returns the final FCS
// tagged with the owning requester.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : crc_frame_arbiter_if.slave (requesters, result, engine handshake)
// All outputs are registered; each is the registered image of the next state.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module crc_frame_arbiter #(
  parameter int                   DATA_WIDTH     = 8,
  parameter int                   CRC_WIDTH      = 32,
  parameter logic [CRC_WIDTH-1:0] FINAL_XOR      = 32'hFFFFFFFF,
  parameter int                   CLR_CYCLES     = 2,
  parameter int                   TIMEOUT_CYCLES = 64
) (
  input logic                clk,
  input logic                rst,
  crc_frame_arbiter_if.slave bus
);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CLR_W = $clog2(CLR_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CLR       = 3'd1,
    S_WAIT_BYTE = 3'd2,
    S_FEED      = 3'd3,
    S_RESULT    = 3'd4
  } state_t;

  state_t                r_state,      w_state_nxt;
  logic                  r_grant,      w_grant_nxt;
  logic                  r_last_grant, w_last_grant_nxt;
  logic                  r_last,       w_last_nxt;
  logic                  r_err,        w_err_nxt;
  logic                  r_done_q;
  logic [TMR_W-1:0]      r_timer,      w_timer_nxt;
  logic [CLR_W-1:0]      r_clr_cnt,    w_clr_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_eng_data,   w_eng_data_nxt;
  logic                  r_eng_rst,    r_eng_start;
  logic                  r_req0_ready, r_req1_ready;
  logic                  r_res_valid,  w_res_valid_nxt;
  logic                  r_res_id,     w_res_id_nxt;
  logic [CRC_WIDTH-1:0]  r_res_crc,    w_res_crc_nxt;
  logic                  r_res_err,    w_res_err_nxt;

  logic                  w_rise;
  logic                  w_gnt_valid;
  logic [DATA_WIDTH-1:0] w_gnt_data;
  logic                  w_gnt_last;

  // Only a fresh done edge completes a byte; a done still high from the
  // previous byte must not count.
  assign w_rise      = bus.eng_done & ~r_done_q;
  assign w_gnt_valid = r_grant ? bus.req1_valid : bus.req0_valid;
  assign w_gnt_data  = r_grant ? bus.req1_data  : bus.req0_data;
  assign w_gnt_last  = r_grant ? bus.req1_last  : bus.req0_last;

  // Next-state, datapath and result computation.
  always_comb begin
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant;
    w_last_grant_nxt = r_last_grant;
    w_last_nxt       = r_last;
    w_err_nxt        = r_err;
    w_timer_nxt      = r_timer;
    w_clr_cnt_nxt    = r_clr_cnt;
    w_eng_data_nxt   = r_eng_data;
    w_res_valid_nxt  = 1'b0;
    w_res_id_nxt     = r_res_id;
    w_res_crc_nxt    = r_res_crc;
    w_res_err_nxt    = r_res_err;
    case (r_state)
      S_IDLE: begin
        if (bus.req0_valid | bus.req1_valid) begin
          // Prefer the requester that did not own the previous frame.
          if (r_last_grant == 1'b0) begin
            w_grant_nxt = bus.req1_valid;
          end else begin
            w_grant_nxt = ~bus.req0_valid;
          end
          w_clr_cnt_nxt = '0;
          w_state_nxt   = S_CLR;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CLR: begin
        if (r_clr_cnt == CLR_W'(CLR_CYCLES - 1)) begin
          w_state_nxt = S_WAIT_BYTE;
        end else begin
          w_clr_cnt_nxt = r_clr_cnt + CLR_W'(1);
        end
      end
      S_WAIT_BYTE: begin
        // Ready is high for the whole of this state, so valid alone accepts.
        if (w_gnt_valid) begin
          w_eng_data_nxt = w_gnt_data;
          w_last_nxt     = w_gnt_last;
          w_timer_nxt    = '0;
          w_state_nxt    = S_FEED;
        end else begin
          w_state_nxt = S_WAIT_BYTE;
        end
      end
      S_FEED: begin
        if (w_rise) begin
          if (r_last) begin
            w_state_nxt = S_RESULT;
          end else begin
            w_state_nxt = S_WAIT_BYTE;
          end
        end else if (r_timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          // This is the last allowed FEED cycle: abandon the frame.
          w_err_nxt   = 1'b1;
          w_state_nxt = S_RESULT;
        end else begin
          w_timer_nxt = r_timer + TMR_W'(1);
        end
      end
      S_RESULT: begin
        w_res_valid_nxt  = 1'b1;
        w_res_id_nxt     = r_grant;
        w_res_crc_nxt    = bus.eng_crc ^ FINAL_XOR;
        w_res_err_nxt    = r_err;
        w_last_grant_nxt = r_grant;
        w_err_nxt        = 1'b0;
        w_state_nxt      = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_last       <= 1'b0;
      r_err        <= 1'b0;
      r_done_q     <= 1'b0;
      r_timer      <= '0;
      r_clr_cnt    <= '0;
      r_eng_data   <= '0;
      r_eng_rst    <= 1'b1;
      r_eng_start  <= 1'b0;
      r_req0_ready <= 1'b0;
      r_req1_ready <= 1'b0;
      r_res_valid  <= 1'b0;
      r_res_id     <= 1'b0;
      r_res_crc    <= '0;
      r_res_err    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_last       <= w_last_nxt;
      r_err        <= w_err_nxt;
      r_done_q     <= bus.eng_done;
      r_timer      <= w_timer_nxt;
      r_clr_cnt    <= w_clr_cnt_nxt;
      r_eng_data   <= w_eng_data_nxt;
      r_eng_rst    <= (w_state_nxt == S_CLR);
      r_eng_start  <= (w_state_nxt == S_FEED);
      r_req0_ready <= (w_state_nxt == S_WAIT_BYTE) & ~w_grant_nxt;
      r_req1_ready <= (w_state_nxt == S_WAIT_BYTE) &  w_grant_nxt;
      r_res_valid  <= w_res_valid_nxt;
      r_res_id     <= w_res_id_nxt;
      r_res_crc    <= w_res_crc_nxt;
      r_res_err    <= w_res_err_nxt;
    end
  end

  assign bus.req0_ready = r_req0_ready;
  assign bus.req1_ready = r_req1_ready;
  assign bus.res_valid  = r_res_valid;
  assign bus.res_id     = r_res_id;
  assign bus.res_crc    = r_res_crc;
  assign bus.res_err    = r_res_err;
  assign bus.eng_rst    = r_eng_rst;
  assign bus.eng_start  = r_eng_start;
  assign bus.eng_data   = r_eng_data;
endmodule
